enemy_slot_sched: RTL and testbench
===================================

Name: enemy_slot_sched

Overview:
- Controller that sequences the two enemy slots feeding the enemy renderer and the damage logic.
- Spawns enemies and steps each one toward its contact position on a slow tick.
- Resolves player attacks into hit flags and issues player-damage and kill pulses.
- Drives the renderer's pos_0/pos_1/hit_0/hit_1 inputs; the renderer only draws.

Parameters:
- SPAN, 9, ticks of walking from spawn to contact (spawn pos = contact + SPAN).
- HIT_RANGE, 2, an attack lands if pos <= contact + HIT_RANGE.
- ATK_PERIOD, 4, step ticks between damage pulses while an enemy is in contact.
- HIT_TICKS, 3, step ticks the hit flag is held before the slot frees.
- IDLE_POS, 31, pos value driven while a slot is idle (off-screen).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- step_tick  in  1  one-cycle pulse at movement rate, synchronous to clk.
- spawn_req  in  2  bit i requests a spawn in slot i (level or pulse).
- attack  in  1  one-cycle player attack pulse.
- attack_slot  in  1  slot targeted by attack.
- pos_0  out  5  slot 0 position; contact position 0.
- pos_1  out  5  slot 1 position; contact position 10.
- hit_0  out  1  slot 0 hit flag.
- hit_1  out  1  slot 1 hit flag.
- alive  out  2  bit i is 1 when slot i is not IDLE.
- damage  out  1  one-cycle player-damage pulse.
- kill  out  1  one-cycle pulse when a slot frees after a hit.

Behaviour:
- Reset (async): both slots IDLE; pos_0 = pos_1 = IDLE_POS; hit_*, alive, damage, kill = 0; all counters 0.
- All outputs are registered.
- Per-slot FSM states: IDLE, WALK, ATTACK, HIT. Contact C = 0 (slot 0), 10 (slot 1).
- IDLE:
  - spawn_req[i] = 1 -> WALK next cycle with pos = C + SPAN.
  - step_tick is not required for a spawn.
- WALK:
  - On step_tick: pos decrements by 1.
  - When the decrement yields pos == C, go to ATTACK in the same update; atk_cnt = 0.
- ATTACK:
  - pos is held at C.
  - On each step_tick, atk_cnt increments.
  - When atk_cnt reaches ATK_PERIOD-1 on a tick: damage request, then atk_cnt = 0.
  - The first damage occurs ATK_PERIOD ticks after entry.
- Attack resolution (WALK or ATTACK):
  - attack with attack_slot == i and pos <= C + HIT_RANGE -> HIT next cycle.
  - pos is frozen; hit_i = 1; hit_cnt = 0.
  - An out-of-range attack, or one aimed at an IDLE/HIT slot, is ignored.
- HIT:
  - hit_i = 1. Each step_tick increments hit_cnt.
  - At HIT_TICKS-1 on a tick: -> IDLE, hit_i = 0, pos = IDLE_POS, kill pulse in the same cycle.
- damage:
  - Registered OR of both slots' damage requests: exactly one pulse even if both slots fire on the same tick.
  - Asserted 1 cycle after the step_tick that caused it.
- kill:
  - One pulse per cycle; if both slots free on the same tick, kill is 2 cycles wide (one per slot).
  - A pending second kill is held in a 1-bit latch.
- Simultaneous events:
  - attack + step_tick in the same cycle for the same slot: the attack wins; no move and no damage from that slot.
  - Hit resolution uses pos before the decrement.
  - spawn_req while not IDLE: ignored, not queued.
  - spawn_req in the same cycle the slot returns to IDLE: ignored; re-spawn takes effect the next cycle.
- pos arithmetic is 5-bit unsigned; it never decrements below C (guaranteed by the WALK->ATTACK rule).
- Reset asserted mid-operation: immediate return to the reset values; any in-flight pulse is dropped.

Decomposition:
- Shared package enemy_pkg:
  - slot state enum (IDLE/WALK/ATTACK/HIT).
  - contact constants CONTACT_0 = 5'd0, CONTACT_1 = 5'd10.
  - POS_W = 5.
- One sub-module, enemy_slot_fsm:
  - Parameterised by contact position.
  - Holds the state, pos, atk_cnt and hit_cnt.
  - Emits damage_req and kill_req.
  - Instantiated twice.
- The top level owns the damage OR and the kill serialisation latch.

Test Plan:
- Reset, spawn_req = 2'b01, 9 step_ticks -> pos_0 counts 9..0, state ATTACK; 4 more ticks -> one damage pulse 1 cycle after the 4th tick; pos_1 stays 31.
- Slot 1 at pos 13, attack with attack_slot = 1 -> miss, pos_1 continues to 12; attack at pos 12 -> hit_1 = 1, pos frozen at 12; 3 ticks -> kill pulse, pos_1 = 31, alive[1] = 0.
- Both slots in ATTACK with aligned atk_cnt -> single damage pulse per 4 ticks; attack slot 0, then 3 ticks -> only slot 1 keeps damaging.
- Same-cycle attack + step_tick on slot 0 at pos 2 -> pos_0 stays 2, hit_0 = 1, no damage.
- Both slots in HIT finishing on the same tick -> kill high 2 consecutive cycles; spawn_req held at 2'b11 -> both re-spawn the following cycle (pos 9 and 19).
- rst asserted asynchronously mid-WALK (pos_0 = 5), between clock edges -> outputs are at reset values before the next edge; after release, no damage or kill pulse.

Source files
------------

// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg
// Types and constants shared by the enemy slot controller and its per-slot
// state machines.
//   POS_W      : width of a slot position
//   CONTACT_0  : contact position of slot 0
//   CONTACT_1  : contact position of slot 1
//   slot_state_t : per-slot state (IDLE / WALK / ATTACK / HIT)
// ---------------------------------------------------------------------------
package enemy_pkg;

    localparam int POS_W = 5;

    localparam logic [POS_W-1:0] CONTACT_0 = 5'd0;
    localparam logic [POS_W-1:0] CONTACT_1 = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_ATTACK = 2'd2,
        ST_HIT    = 2'd3
    } slot_state_t;

endpackage

// File: rtl/enemy_slot_fsm.sv
// ---------------------------------------------------------------------------
// enemy_slot_fsm
// One enemy slot: spawns at CONTACT+SPAN, walks toward CONTACT on step ticks,
// raises damage requests periodically while in contact, and is knocked into
// HIT by an in-range attack before freeing itself.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   step_tick_i    : movement-rate pulse
//   spawn_i        : spawn request for this slot
//   attack_i       : player attack aimed at this slot
//   pos_o          : registered position (IDLE_POS while idle)
//   hit_o          : registered hit flag
//   alive_o        : slot is not idle
//   damage_req_o   : combinational, this tick completes an attack period
//   kill_req_o     : combinational, this tick frees the slot after a hit
// ---------------------------------------------------------------------------
module enemy_slot_fsm
    import enemy_pkg::*;
#(
    parameter logic [POS_W-1:0] CONTACT    = CONTACT_0,
    parameter int               SPAN       = 9,
    parameter int               HIT_RANGE  = 2,
    parameter int               ATK_PERIOD = 4,
    parameter int               HIT_TICKS  = 3,
    parameter int               IDLE_POS   = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_tick_i,
    input  logic             spawn_i,
    input  logic             attack_i,
    output logic [POS_W-1:0] pos_o,
    output logic             hit_o,
    output logic             alive_o,
    output logic             damage_req_o,
    output logic             kill_req_o
);

    localparam int AW = (ATK_PERIOD > 1) ? $clog2(ATK_PERIOD) : 1;
    localparam int HW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

    localparam logic [POS_W-1:0] SPAWN_POS = CONTACT + POS_W'(SPAN);
    localparam logic [POS_W-1:0] HIT_LIM   = CONTACT + POS_W'(HIT_RANGE);
    localparam logic [POS_W-1:0] IDLE_P    = POS_W'(IDLE_POS);
    localparam logic [AW-1:0]    ATK_LAST  = AW'(ATK_PERIOD - 1);
    localparam logic [HW-1:0]    HIT_LAST  = HW'(HIT_TICKS - 1);

    slot_state_t      state_q;
    logic [POS_W-1:0] pos_q;
    logic             hit_q;
    logic [AW-1:0]    atk_cnt_q;
    logic [HW-1:0]    hit_cnt_q;

    logic [POS_W-1:0] pos_dec_d;
    logic             hit_now_d;

    // Hit resolution looks at the position before any decrement this cycle,
    // and takes priority over movement and damage from the same slot.
    always_comb begin
        pos_dec_d = pos_q - POS_W'(1);
        hit_now_d = attack_i && (pos_q <= HIT_LIM) &&
                    ((state_q == ST_WALK) || (state_q == ST_ATTACK));
    end

    assign damage_req_o = step_tick_i && !hit_now_d &&
                          (state_q == ST_ATTACK) && (atk_cnt_q == ATK_LAST);
    assign kill_req_o   = step_tick_i && (state_q == ST_HIT) &&
                          (hit_cnt_q == HIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pos_q     <= IDLE_P;
            hit_q     <= 1'b0;
            atk_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (spawn_i) begin
                        state_q <= ST_WALK;
                        pos_q   <= SPAWN_POS;
                    end
                end
                ST_WALK: begin
                    if (hit_now_d) begin
                        state_q   <= ST_HIT;
                        hit_q     <= 1'b1;
                        hit_cnt_q <= '0;
                    end else if (step_tick_i) begin
                        pos_q <= pos_dec_d;
                        if (pos_dec_d == CONTACT) begin
                            state_q   <= ST_ATTACK;
                            atk_cnt_q <= '0;
                        end
                    end
                end
                ST_ATTACK: begin
                    if (hit_now_d) begin
                        state_q   <= ST_HIT;
                        hit_q     <= 1'b1;
                        hit_cnt_q <= '0;
                    end else if (step_tick_i) begin
                        if (atk_cnt_q == ATK_LAST) atk_cnt_q <= '0;
                        else                       atk_cnt_q <= atk_cnt_q + AW'(1);
                    end
                end
                ST_HIT: begin
                    if (step_tick_i) begin
                        if (hit_cnt_q == HIT_LAST) begin
                            state_q <= ST_IDLE;
                            hit_q   <= 1'b0;
                            pos_q   <= IDLE_P;
                        end else begin
                            hit_cnt_q <= hit_cnt_q + HW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pos_o   = pos_q;
    assign hit_o   = hit_q;
    assign alive_o = (state_q != ST_IDLE);

endmodule

// File: rtl/enemy_slot_sched.sv
// ---------------------------------------------------------------------------
// enemy_slot_sched
// Sequences the two enemy slots feeding the renderer and the damage logic.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   step_tick       : movement-rate pulse
//   spawn_req[1:0]  : per-slot spawn request
//   attack          : player attack pulse
//   attack_slot     : slot targeted by attack
//   pos_0, pos_1    : slot positions (contacts 0 and 10)
//   hit_0, hit_1    : slot hit flags
//   alive[1:0]      : slot is not idle
//   damage          : one-cycle player-damage pulse
//   kill            : one-cycle pulse per freed slot
// ---------------------------------------------------------------------------
module enemy_slot_sched
    import enemy_pkg::*;
#(
    parameter int SPAN       = 9,
    parameter int HIT_RANGE  = 2,
    parameter int ATK_PERIOD = 4,
    parameter int HIT_TICKS  = 3,
    parameter int IDLE_POS   = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_tick,
    input  logic [1:0]       spawn_req,
    input  logic             attack,
    input  logic             attack_slot,
    output logic [POS_W-1:0] pos_0,
    output logic [POS_W-1:0] pos_1,
    output logic             hit_0,
    output logic             hit_1,
    output logic [1:0]       alive,
    output logic             damage,
    output logic             kill
);

    logic [1:0] dmg_req;
    logic [1:0] kill_req;
    logic       damage_q;
    logic       kill_q;
    logic       kill_pend_q;
    logic [1:0] kill_cnt_d;

    enemy_slot_fsm #(
        .CONTACT(CONTACT_0), .SPAN(SPAN), .HIT_RANGE(HIT_RANGE),
        .ATK_PERIOD(ATK_PERIOD), .HIT_TICKS(HIT_TICKS), .IDLE_POS(IDLE_POS)
    ) u_slot0 (
        .clk          (clk),
        .rst          (rst),
        .step_tick_i  (step_tick),
        .spawn_i      (spawn_req[0]),
        .attack_i     (attack && (attack_slot == 1'b0)),
        .pos_o        (pos_0),
        .hit_o        (hit_0),
        .alive_o      (alive[0]),
        .damage_req_o (dmg_req[0]),
        .kill_req_o   (kill_req[0])
    );

    enemy_slot_fsm #(
        .CONTACT(CONTACT_1), .SPAN(SPAN), .HIT_RANGE(HIT_RANGE),
        .ATK_PERIOD(ATK_PERIOD), .HIT_TICKS(HIT_TICKS), .IDLE_POS(IDLE_POS)
    ) u_slot1 (
        .clk          (clk),
        .rst          (rst),
        .step_tick_i  (step_tick),
        .spawn_i      (spawn_req[1]),
        .attack_i     (attack && (attack_slot == 1'b1)),
        .pos_o        (pos_1),
        .hit_o        (hit_1),
        .alive_o      (alive[1]),
        .damage_req_o (dmg_req[1]),
        .kill_req_o   (kill_req[1])
    );

    // Outstanding kills this cycle: one may be emitted, any surplus waits in
    // the pending bit. Two kills can only coincide when both slots free on
    // the same tick, so one bit of backlog is enough.
    assign kill_cnt_d = 2'(kill_pend_q) + 2'(kill_req[0]) + 2'(kill_req[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            damage_q    <= 1'b0;
            kill_q      <= 1'b0;
            kill_pend_q <= 1'b0;
        end else begin
            damage_q    <= |dmg_req;
            kill_q      <= |kill_cnt_d;
            kill_pend_q <= (kill_cnt_d > 2'd1);
        end
    end

    assign damage = damage_q;
    assign kill   = kill_q;

endmodule

// File: tb/tb_enemy_slot_sched.sv
module tb_enemy_slot_sched;
    import enemy_pkg::*;

    localparam int SPAN = 9, HIT_RANGE = 2, ATK_PERIOD = 4, HIT_TICKS = 3, IDLE_POS = 31;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_tick = 1'b0;
    logic [1:0] spawn_req = 2'b00;
    logic       attack = 1'b0;
    logic       attack_slot = 1'b0;
    logic [4:0] pos_0, pos_1;
    logic       hit_0, hit_1, damage, kill;
    logic [1:0] alive;

    always #5 clk = ~clk;

    enemy_slot_sched dut (
        .clk(clk), .rst(rst), .step_tick(step_tick), .spawn_req(spawn_req),
        .attack(attack), .attack_slot(attack_slot), .pos_0(pos_0), .pos_1(pos_1),
        .hit_0(hit_0), .hit_1(hit_1), .alive(alive), .damage(damage), .kill(kill)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: each slot tracks how far it has walked, how long it
    // has been in contact and how long it has been hit.
    bit m_alive[2], m_hit[2];
    int walked[2], in_contact[2], hit_ticks[2], frozen[2];
    int backlog;
    bit m_dmg, m_kill;

    function automatic int contact_of(int i);
        return (i == 0) ? 0 : 10;
    endfunction

    function automatic int m_pos(int i);
        if (!m_alive[i]) return IDLE_POS;
        if (m_hit[i])    return frozen[i];
        return contact_of(i) + SPAN - walked[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_alive[i] = 0; m_hit[i] = 0; walked[i] = 0;
            in_contact[i] = 0; hit_ticks[i] = 0; frozen[i] = 0;
        end
        backlog = 0; m_dmg = 0; m_kill = 0;
    endtask

    task automatic model_step(input bit t, input logic [1:0] sp, input bit a, input bit s);
        int freed = 0;
        int total;
        bit dreq = 0;
        for (int i = 0; i < 2; i++) begin
            int p = m_pos(i);
            if (!m_alive[i]) begin
                if (sp[i]) begin
                    m_alive[i] = 1; m_hit[i] = 0; walked[i] = 0; in_contact[i] = 0;
                end
            end else if (m_hit[i]) begin
                if (t) begin
                    hit_ticks[i]++;
                    if (hit_ticks[i] == HIT_TICKS) begin
                        m_alive[i] = 0; m_hit[i] = 0; freed++;
                    end
                end
            end else if (a && (int'(s) == i) && (p <= contact_of(i) + HIT_RANGE)) begin
                m_hit[i] = 1; hit_ticks[i] = 0; frozen[i] = p;
            end else if (t) begin
                if (walked[i] < SPAN) walked[i]++;
                else begin
                    in_contact[i]++;
                    if (in_contact[i] % ATK_PERIOD == 0) dreq = 1;
                end
            end
        end
        m_dmg   = dreq;
        total   = backlog + freed;
        m_kill  = (total > 0);
        backlog = (total > 0) ? total - 1 : 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("pos_0", 32'(pos_0), m_pos(0));
        chk("pos_1", 32'(pos_1), m_pos(1));
        chk("hit_0", 32'(hit_0), int'(m_hit[0]));
        chk("hit_1", 32'(hit_1), int'(m_hit[1]));
        chk("alive", 32'(alive), int'({m_alive[1], m_alive[0]}));
        chk("damage", 32'(damage), int'(m_dmg));
        chk("kill", 32'(kill), int'(m_kill));
    endtask

    task automatic cycle(input bit t, input logic [1:0] sp, input bit a, input bit s);
        @(negedge clk);
        step_tick = t; spawn_req = sp; attack = a; attack_slot = s;
        @(posedge clk);
        model_step(t, sp, a, s);
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cycle(1, 2'b00, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        step_tick = 0; spawn_req = 0; attack = 0; attack_slot = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        check_model();
    endtask

    typedef struct {
        bit t; logic [1:0] sp; bit a; bit s;
        int p0; int p1; bit h0; bit h1; logic [1:0] al; bit d; bit k;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit t, logic [1:0] sp, bit a, bit s, int p0, int p1,
                                bit h0, bit h1, logic [1:0] al, bit d, bit k);
        vec_t v;
        v.t = t; v.sp = sp; v.a = a; v.s = s; v.p0 = p0; v.p1 = p1;
        v.h0 = h0; v.h1 = h1; v.al = al; v.d = d; v.k = k;
        tbl.push_back(v);
    endfunction

    initial begin
        model_reset();
        // Spawn slot 0, walk to contact, first damage after ATK_PERIOD ticks,
        // then an ignored attack on idle slot 1 and a kill of slot 0.
        add(0, 2'b01, 0, 0, 9, 31, 0, 0, 2'b01, 0, 0);
        for (int k = 0; k < 9; k++) add(1, 2'b00, 0, 0, 8 - k, 31, 0, 0, 2'b01, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 2'b00, 0, 0, 0, 31, 0, 0, 2'b01, 0, 0);
        add(1, 2'b00, 0, 0, 0, 31, 0, 0, 2'b01, 1, 0);
        add(0, 2'b00, 0, 0, 0, 31, 0, 0, 2'b01, 0, 0);
        add(0, 2'b00, 1, 1, 0, 31, 0, 0, 2'b01, 0, 0);
        add(1, 2'b01, 1, 0, 0, 31, 1, 0, 2'b01, 0, 0);
        add(1, 2'b00, 0, 0, 0, 31, 1, 0, 2'b01, 0, 0);
        add(1, 2'b00, 0, 0, 0, 31, 1, 0, 2'b01, 0, 0);
        add(1, 2'b00, 0, 0, 31, 31, 0, 0, 2'b00, 0, 1);
        add(0, 2'b00, 0, 0, 31, 31, 0, 0, 2'b00, 0, 0);

        // Reset state
        do_reset();
        chk("rst_pos_0", 32'(pos_0), 31);
        chk("rst_pos_1", 32'(pos_1), 31);
        chk("rst_alive", 32'(alive), 0);

        foreach (tbl[n]) begin
            cycle(tbl[n].t, tbl[n].sp, tbl[n].a, tbl[n].s);
            chk("tbl_pos_0", 32'(pos_0), tbl[n].p0);
            chk("tbl_pos_1", 32'(pos_1), tbl[n].p1);
            chk("tbl_hit_0", 32'(hit_0), int'(tbl[n].h0));
            chk("tbl_hit_1", 32'(hit_1), int'(tbl[n].h1));
            chk("tbl_alive", 32'(alive), int'(tbl[n].al));
            chk("tbl_damage", 32'(damage), int'(tbl[n].d));
            chk("tbl_kill", 32'(kill), int'(tbl[n].k));
        end

        // Slot 1 miss at 13, hit at 12, then freed
        do_reset();
        cycle(0, 2'b10, 0, 0);
        ticks(6);
        chk("s1_pos13", 32'(pos_1), 13);
        cycle(1, 2'b00, 1, 1);
        chk("s1_miss_pos", 32'(pos_1), 12);
        chk("s1_miss_hit", 32'(hit_1), 0);
        cycle(0, 2'b00, 1, 1);
        chk("s1_hit", 32'(hit_1), 1);
        chk("s1_hit_pos", 32'(pos_1), 12);
        ticks(3);
        chk("s1_kill", 32'(kill), 1);
        chk("s1_kill_pos", 32'(pos_1), 31);
        chk("s1_kill_alive", 32'(alive), 0);
        cycle(0, 2'b00, 0, 0);
        chk("s1_kill_end", 32'(kill), 0);

        // Both slots in contact, aligned damage; then slot 0 is knocked out
        do_reset();
        cycle(0, 2'b11, 0, 0);
        ticks(12);
        chk("both_nodmg", 32'(damage), 0);
        ticks(1);
        chk("both_dmg", 32'(damage), 1);
        cycle(0, 2'b00, 0, 0);
        chk("both_dmg_single", 32'(damage), 0);
        cycle(0, 2'b00, 1, 0);
        chk("both_hit0", 32'(hit_0), 1);
        ticks(3);
        chk("both_kill0", 32'(kill), 1);
        ticks(1);
        chk("s1_alone_dmg", 32'(damage), 1);

        // Attack and tick together on slot 0 at pos 2
        do_reset();
        cycle(0, 2'b01, 0, 0);
        ticks(7);
        cycle(1, 2'b00, 1, 0);
        chk("same_pos", 32'(pos_0), 2);
        chk("same_hit", 32'(hit_0), 1);
        chk("same_dmg", 32'(damage), 0);

        // Both slots free on the same tick, then re-spawn
        do_reset();
        cycle(0, 2'b11, 0, 0);
        ticks(7);
        cycle(0, 2'b00, 1, 0);
        cycle(0, 2'b00, 1, 1);
        ticks(2);
        cycle(1, 2'b11, 0, 0);
        chk("dk_kill1", 32'(kill), 1);
        chk("dk_alive", 32'(alive), 0);
        cycle(0, 2'b11, 0, 0);
        chk("dk_kill2", 32'(kill), 1);
        chk("dk_resp0", 32'(pos_0), 9);
        chk("dk_resp1", 32'(pos_1), 19);
        cycle(0, 2'b00, 0, 0);
        chk("dk_kill_end", 32'(kill), 0);

        // Asynchronous reset between edges mid-walk
        do_reset();
        cycle(0, 2'b01, 0, 0);
        ticks(4);
        chk("ar_pos5", 32'(pos_0), 5);
        @(negedge clk);
        step_tick = 0; spawn_req = 0; attack = 0;
        @(posedge clk);
        model_step(0, 2'b00, 0, 0);
        #3;
        rst = 1;
        #1;
        chk("ar_pos_0", 32'(pos_0), 31);
        chk("ar_alive", 32'(alive), 0);
        chk("ar_hit_0", 32'(hit_0), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(k % 2, 2'b00, 0, 0);
            chk("ar_no_dmg", 32'(damage), 0);
            chk("ar_no_kill", 32'(kill), 0);
        end

        // Randomized run against the model
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            cycle($urandom_range(0, 2) == 0,
                  ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                  $urandom_range(0, 4) == 0,
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
